// File: rtl/idli_pkg.sv
// Shared constants, types and serialiser state encoding
// for the nibble-serial instruction stream.
package idli_pkg;

    localparam int IDLI_NIB_W         = 4;
    localparam int IDLI_NIBS_PER_WORD = 4;
    localparam int IDLI_WORD_W        = IDLI_NIB_W * IDLI_NIBS_PER_WORD;

    typedef logic [IDLI_NIB_W-1:0]  idli_pkg_nib_t;
    typedef logic [IDLI_WORD_W-1:0] idli_pkg_word_t;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_t;

endpackage

// File: rtl/idli_ser_fifo_m.sv
// Synchronous DEPTH-entry word FIFO with push/pop/flush.
// Ports: clk, rst (sync, active-high), flush, push/data,
//        pop, head, count, full, empty.
module idli_ser_fifo_m
    import idli_pkg::*;
#(
    parameter int WORD_W = IDLI_WORD_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/idli_nibble_ser_m.sv
// Nibble-serial instruction transmitter: buffers words from fetch
// and streams each as NIBS nibbles, LS nibble first, to decode.
// Ports: i_ser_gck clock, i_ser_rst sync reset, i_ser_word/_vld/
//        o_ser_word_rdy input handshake, i_ser_stall hold,
//        i_ser_flush discard, o_ser_enc/_vld/o_ser_first stream,
//        o_ser_busy activity flag.
// Optional: IDLI_SER_PARITY_EN adds o_ser_par, the XOR of o_ser_enc.
module idli_nibble_ser_m
    import idli_pkg::*;
#(
    parameter int WORD_W = IDLI_WORD_W,
    parameter int NIB_W  = IDLI_NIB_W,
    parameter int DEPTH  = 2
) (
    input  logic              i_ser_gck,
    input  logic              i_ser_rst,
    input  logic [WORD_W-1:0] i_ser_word,
    input  logic              i_ser_word_vld,
    output logic              o_ser_word_rdy,
    input  logic              i_ser_stall,
    input  logic              i_ser_flush,
    output logic [NIB_W-1:0]  o_ser_enc,
    output logic              o_ser_enc_vld,
    output logic              o_ser_first,
    output logic              o_ser_busy
`ifdef IDLI_SER_PARITY_EN
    ,
    output logic              o_ser_par
`endif
);

    localparam int NIBS  = WORD_W / NIB_W;
    localparam int K_W   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (WORD_W % NIB_W != 0) begin : g_bad_width
        $error("WORD_W must be a multiple of NIB_W");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("DEPTH must be at least 1");
    end

    ser_state_t        state;
    logic [WORD_W-1:0] sr;
    logic [K_W-1:0]    k;

    logic [WORD_W-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    logic              accept;
    logic              last;
    logic              slot;
    logic              load;
    logic              adv;
    logic              pop;
    logic              push;
    logic [WORD_W-1:0] nxt_word;
    logic [WORD_W-1:0] shifted;
    logic [NIB_W-1:0]  nxt_nib;

    // Ready depends only on registered count, never on word_vld.
    assign o_ser_word_rdy = !i_ser_rst & !i_ser_flush & !full;
    assign accept         = i_ser_word_vld & o_ser_word_rdy;

    assign last = (k == K_W'(NIBS - 1));

    // A new word may enter the shift register when idle (stall only
    // freezes an active stream) or as the last nibble leaves.
    assign slot = (state == SER_IDLE)
                | ((state == SER_SEND) & last & !i_ser_stall);
    assign load = slot & (!empty | accept);
    assign adv  = (state == SER_SEND) & !i_ser_stall & !last;

    // FIFO head has priority; an incoming word bypasses the FIFO
    // only when it is empty and the shift register is taking a word.
    assign pop      = load & !empty;
    assign push     = accept & !(load & empty);
    assign nxt_word = empty ? i_ser_word : head;

    // Shift register moves right so the next nibble is always low.
    assign shifted = sr >> NIB_W;
    assign nxt_nib = load ? nxt_word[NIB_W-1:0] : shifted[NIB_W-1:0];

    assign o_ser_busy = (state == SER_SEND) | (count != '0);

    idli_ser_fifo_m #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk   (i_ser_gck),
        .rst   (i_ser_rst),
        .flush (i_ser_flush),
        .push  (push),
        .data  (i_ser_word),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge i_ser_gck) begin
        if (i_ser_rst) begin
            state         <= SER_IDLE;
            sr            <= '0;
            k             <= '0;
            o_ser_enc     <= '0;
            o_ser_enc_vld <= 1'b0;
            o_ser_first   <= 1'b0;
        end else if (i_ser_flush) begin
            state         <= SER_IDLE;
            k             <= '0;
            o_ser_enc_vld <= 1'b0;
            o_ser_first   <= 1'b0;
        end else if (load) begin
            state         <= SER_SEND;
            sr            <= nxt_word;
            k             <= '0;
            o_ser_enc     <= nxt_nib;
            o_ser_enc_vld <= 1'b1;
            o_ser_first   <= 1'b1;
        end else if (adv) begin
            sr            <= shifted;
            k             <= k + K_W'(1);
            o_ser_enc     <= nxt_nib;
            o_ser_first   <= 1'b0;
        end else if ((state == SER_SEND) && !i_ser_stall) begin
            // Last nibble sent and nothing waiting: enc keeps its value.
            state         <= SER_IDLE;
            o_ser_enc_vld <= 1'b0;
            o_ser_first   <= 1'b0;
        end
    end

`ifdef IDLI_SER_PARITY_EN
    always_ff @(posedge i_ser_gck) begin
        if (i_ser_rst) begin
            o_ser_par <= 1'b0;
        end else if (!i_ser_flush && (load || adv)) begin
            o_ser_par <= ^nxt_nib;
        end
    end
`endif

endmodule

// File: tb/tb_idli_nibble_ser_m.sv
// Self-checking bench for idli_nibble_ser_m: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_idli_nibble_ser_m;

    localparam int DEPTH = 2;
    localparam int NIBS  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word;
    logic        word_vld;
    logic        rdy;
    logic        stall;
    logic        flush;
    logic [3:0]  enc;
    logic        enc_vld;
    logic        first;
    logic        busy;
`ifdef IDLI_SER_PARITY_EN
    logic        par;
`endif

    always #5 clk = ~clk;

    idli_nibble_ser_m #(
        .WORD_W (16),
        .NIB_W  (4),
        .DEPTH  (DEPTH)
    ) dut (
        .i_ser_gck      (clk),
        .i_ser_rst      (rst),
        .i_ser_word     (word),
        .i_ser_word_vld (word_vld),
        .o_ser_word_rdy (rdy),
        .i_ser_stall    (stall),
        .i_ser_flush    (flush),
        .o_ser_enc      (enc),
        .o_ser_enc_vld  (enc_vld),
        .o_ser_first    (first),
        .o_ser_busy     (busy)
`ifdef IDLI_SER_PARITY_EN
        ,
        .o_ser_par      (par)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: words not yet started wait in pend; cur is
    // the word being streamed, idx its nibble number.
    logic [15:0] pend[$];
    logic [15:0] cur;
    int          idx;
    bit          active;
    logic [3:0]  m_enc;
    bit          m_vld;
    bit          m_first;
    bit          m_par;

    function automatic logic [3:0] nib(input logic [15:0] w, input int i);
        return 4'((w >> (4 * i)) & 16'hF);
    endfunction

    task automatic model(input bit r, input bit f, input bit s,
                         input bit v, input logic [15:0] w);
        bit acc;
        bit start;
        start = 0;
        if (r) begin
            pend.delete();
            active  = 0;
            m_enc   = 0;
            m_vld   = 0;
            m_first = 0;
        end else if (f) begin
            pend.delete();
            active  = 0;
            m_vld   = 0;
            m_first = 0;
        end else begin
            acc = v && (pend.size() < DEPTH);
            if (active && !s && idx < NIBS - 1) begin
                idx++;
                m_enc   = nib(cur, idx);
                m_first = 0;
                if (acc) pend.push_back(w);
            end else if (!active || (idx == NIBS - 1 && !s)) begin
                if (pend.size() != 0) begin
                    cur = pend.pop_front();
                    if (acc) pend.push_back(w);
                    start = 1;
                end else if (acc) begin
                    cur   = w;
                    start = 1;
                end else begin
                    active  = 0;
                    m_vld   = 0;
                    m_first = 0;
                end
                if (start) begin
                    active  = 1;
                    idx     = 0;
                    m_enc   = nib(cur, 0);
                    m_vld   = 1;
                    m_first = 1;
                end
            end else if (acc) begin
                pend.push_back(w);
            end
        end
        m_par = ^m_enc;
    endtask

    // One clock: drive at negedge, check ready, then check outputs
    // just after the rising edge.
    task automatic step(input bit r, input bit f, input bit s,
                        input bit v, input logic [15:0] w,
                        output logic rdy_seen);
        bit m_rdy;
        @(negedge clk);
        rst      = r;
        flush    = f;
        stall    = s;
        word_vld = v;
        word     = w;
        #1;
        m_rdy    = !r && !f && (pend.size() < DEPTH);
        rdy_seen = rdy;
        chk("rdy", {31'd0, rdy}, {31'd0, m_rdy});
        model(r, f, s, v, w);
        @(posedge clk);
        #1;
        chk("enc", {28'd0, enc}, {28'd0, m_enc});
        chk("vld", {31'd0, enc_vld}, {31'd0, m_vld});
        chk("first", {31'd0, first}, {31'd0, m_first});
        chk("busy", {31'd0, busy},
            {31'd0, (active || pend.size() != 0)});
`ifdef IDLI_SER_PARITY_EN
        chk("par", {31'd0, par}, {31'd0, m_par});
`endif
    endtask

    task automatic idle(input int n);
        logic d;
        repeat (n) step(0, 0, 0, 0, 16'h0, d);
    endtask

    task automatic reset_dut();
        logic d;
        step(1, 0, 0, 0, 16'h0, d);
        step(1, 0, 0, 0, 16'h0, d);
        chk("rst_rdy", {31'd0, d}, 32'd0);
    endtask

    initial begin
        logic       d;
        logic [3:0] bb[8];
        bit         got;

        rst      = 1;
        flush    = 0;
        stall    = 0;
        word_vld = 0;
        word     = 0;
        m_enc    = 0;
        m_vld    = 0;
        m_first  = 0;
        m_par    = 0;
        active   = 0;
        idx      = 0;
        cur      = 0;

        reset_dut();
        chk("rst_state", {25'd0, enc, enc_vld, first, busy}, 32'd0);

        // Single word, LS nibble first, then vld drops.
        step(0, 0, 0, 1, 16'hA5C3, d);
        chk("sw_n0", {26'd0, first, enc_vld, enc}, {26'd0, 2'b11, 4'h3});
        step(0, 0, 0, 0, 16'h0, d);
        chk("sw_n1", {26'd0, first, enc_vld, enc}, {26'd0, 2'b01, 4'hC});
        step(0, 0, 0, 0, 16'h0, d);
        chk("sw_n2", {28'd0, enc}, 32'h5);
        step(0, 0, 0, 0, 16'h0, d);
        chk("sw_n3", {28'd0, enc}, 32'hA);
        step(0, 0, 0, 0, 16'h0, d);
        chk("sw_end", {26'd0, first, enc_vld, enc}, {26'd0, 2'b00, 4'hA});

        // Back-to-back: no bubble between words.
        bb = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
        step(0, 0, 0, 1, 16'h1234, d);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) step(0, 0, 0, i == 1, 16'h5678, d);
            chk("bb_nib", {26'd0, first, enc_vld, enc},
                {26'd0, (i % 4) == 0, 1'b1, bb[i]});
        end
        idle(2);

        // Full: three words fit while stalled, a fourth is refused.
        step(0, 0, 1, 1, 16'h1111, d);
        step(0, 0, 1, 1, 16'h2222, d);
        step(0, 0, 1, 1, 16'h3333, d);
        chk("full_rdy3", {31'd0, d}, 32'd1);
        step(0, 0, 1, 1, 16'h4444, d);
        chk("full_rdy4", {31'd0, d}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            step(0, 0, 0, 1, 16'h4444, d);
            got = d;
        end
        chk("full_accept", {31'd0, got}, 32'd1);
        idle(18);
        chk("full_drain", {30'd0, enc_vld, busy}, 32'd0);

        // Stall during nibble 1 of 0xBEEF.
        step(0, 0, 0, 1, 16'hBEEF, d);
        step(0, 0, 0, 0, 16'h0, d);
        chk("st_n1", {28'd0, enc}, 32'hE);
        repeat (3) begin
            step(0, 0, 1, 0, 16'h0, d);
            chk("st_hold", {27'd0, enc_vld, enc}, {27'd0, 1'b1, 4'hE});
        end
        step(0, 0, 0, 0, 16'h0, d);
        chk("st_n2", {28'd0, enc}, 32'hE);
        step(0, 0, 0, 0, 16'h0, d);
        chk("st_n3", {28'd0, enc}, 32'hB);
        idle(2);

        // Flush at nibble 2 of 0xCAFE with 0x1234 queued, under stall.
        step(0, 0, 0, 1, 16'hCAFE, d);
        step(0, 0, 0, 1, 16'h1234, d);
        step(0, 0, 0, 0, 16'h0, d);
        chk("fl_n2", {28'd0, enc}, 32'hA);
        step(0, 1, 1, 1, 16'h9999, d);
        chk("fl_rdy", {31'd0, d}, 32'd0);
        chk("fl_out", {29'd0, enc_vld, first, busy}, 32'd0);
        idle(2);
        chk("fl_gone", {30'd0, enc_vld, busy}, 32'd0);

        // Same with reset.
        step(0, 0, 0, 1, 16'hCAFE, d);
        step(0, 0, 0, 1, 16'h1234, d);
        step(0, 0, 0, 0, 16'h0, d);
        step(1, 0, 0, 1, 16'h9999, d);
        chk("rs_out", {25'd0, enc, enc_vld, first, busy}, 32'd0);
        idle(2);
        chk("rs_gone", {30'd0, enc_vld, busy}, 32'd0);

`ifdef IDLI_SER_PARITY_EN
        step(0, 0, 0, 1, 16'h7F10, d);
        chk("par0", {31'd0, par}, 32'd0);
        step(0, 0, 0, 0, 16'h0, d);
        chk("par1", {31'd0, par}, 32'd1);
        step(0, 0, 0, 0, 16'h0, d);
        chk("par2", {31'd0, par}, 32'd0);
        step(0, 0, 0, 0, 16'h0, d);
        chk("par3", {31'd0, par}, 32'd1);
        idle(2);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 60,
                 16'($urandom), d);
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
